// File: rtl/wb_master_seq.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_seq
// Purpose  : Wishbone classic initiator. Accepts one read/write command on a
//            valid/ready request port, runs exactly one WB cycle for it, and
//            returns read data plus a timeout status on a valid/ready
//            response port. One command is outstanding at a time.
// Ports    : clk, rst_n             - clock, async active-low reset
//            req_val/req_rdy        - command handshake
//            req_we/adr/sel/dat     - command fields
//            rsp_val/rsp_rdy        - response handshake
//            rsp_dat/rsp_err        - read data (0 for writes) / timeout flag
//            wbm_*                  - Wishbone classic initiator port
//            busy                   - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_seq #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_dat,
    output logic        rsp_val,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter value on the last permitted bus cycle before abort.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == C_CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        cnt_d     = cnt_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_val) begin
                    we_d    = req_we;
                    sel_d   = req_sel;
                    adr_d   = req_adr;
                    dat_d   = req_dat;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack is tested first so it wins over a coincident timeout.
                if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (timeout_hit) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = 32'hFFFF_FFFF;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                // Going back to IDLE first guarantees no accept in this cycle.
                if (rsp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            cnt_q     <= '0;
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            cnt_q     <= cnt_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign req_rdy   = (state_q == ST_IDLE);
    assign rsp_val   = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_seq
// Purpose  : Directed self-checking bench for wb_master_seq (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_master_seq;

    logic        clk;
    logic        rst_n;
    logic        req_val;
    logic        req_rdy;
    logic        req_we;
    logic [31:0] req_adr;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        rsp_val;
    logic        rsp_rdy;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    wb_master_seq #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_sel   (req_sel),
        .req_dat   (req_dat),
        .rsp_val   (rsp_val),
        .rsp_rdy   (rsp_rdy),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command; caller is in IDLE. Returns one cycle after acceptance.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
        req_val = 1'b1;
        req_we  = we;
        req_adr = adr;
        req_sel = sel;
        req_dat = dat;
        tick();
        req_val = 1'b0;
    endtask

    task automatic consume();
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
    endtask

    int n_cyc;

    initial begin
        rst_n     = 1'b0;
        req_val   = 1'b0;
        req_we    = 1'b0;
        req_adr   = 32'h0;
        req_sel   = 4'h0;
        req_dat   = 32'h0;
        rsp_rdy   = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;

        // Reset state
        #12;
        check_val("rst_cyc",  {31'h0, wbm_cyc_o}, 32'h0);
        check_val("rst_stb",  {31'h0, wbm_stb_o}, 32'h0);
        check_val("rst_adr",  wbm_adr_o, 32'h0);
        check_val("rst_dat",  wbm_dat_o, 32'h0);
        check_val("rst_rval", {31'h0, rsp_val}, 32'h0);
        check_val("rst_rdat", rsp_dat, 32'h0);
        check_val("rst_rerr", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("rst_rdy",  {31'h0, req_rdy}, 32'h1);
        check_val("rst_busy", {31'h0, busy}, 32'h0);

        // 1. Write, ack two cycles after stb rises
        issue(1'b1, 32'h0010_0004, 4'hF, 32'hA5A5_0001);
        check_val("t1_cyc",  {31'h0, wbm_cyc_o}, 32'h1);
        check_val("t1_stb",  {31'h0, wbm_stb_o}, 32'h1);
        check_val("t1_we",   {31'h0, wbm_we_o}, 32'h1);
        check_val("t1_sel",  {28'h0, wbm_sel_o}, 32'hF);
        check_val("t1_adr",  wbm_adr_o, 32'h0010_0004);
        check_val("t1_dat",  wbm_dat_o, 32'hA5A5_0001);
        check_val("t1_rdy",  {31'h0, req_rdy}, 32'h0);
        check_val("t1_busy", {31'h0, busy}, 32'h1);
        tick();
        tick();
        check_val("t1_cyc_hold", {31'h0, wbm_cyc_o}, 32'h1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        wbm_ack_i = 1'b0;
        check_val("t1_cyc_drop", {31'h0, wbm_cyc_o}, 32'h0);
        check_val("t1_rval", {31'h0, rsp_val}, 32'h1);
        check_val("t1_rdat", rsp_dat, 32'h0);
        check_val("t1_rerr", {31'h0, rsp_err}, 32'h0);
        consume();
        check_val("t1_rval_clr", {31'h0, rsp_val}, 32'h0);
        check_val("t1_idle_rdy", {31'h0, req_rdy}, 32'h1);
        check_val("t1_adr_keep", wbm_adr_o, 32'h0010_0004);

        // 2. Read, ack in first bus cycle, response one cycle later
        issue(1'b0, 32'h0001_0000, 4'hF, 32'h0);
        check_val("t2_we",   {31'h0, wbm_we_o}, 32'h0);
        check_val("t2_adr",  wbm_adr_o, 32'h0001_0000);
        check_val("t2_rval0", {31'h0, rsp_val}, 32'h0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        check_val("t2_rval", {31'h0, rsp_val}, 32'h1);
        check_val("t2_rdat", rsp_dat, 32'h1234_5678);
        check_val("t2_rerr", {31'h0, rsp_err}, 32'h0);
        consume();

        // 3. Read with no ack: cyc high for exactly TIMEOUT cycles
        issue(1'b0, 32'h0000_0040, 4'h3, 32'h0);
        n_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (!wbm_cyc_o) break;
            n_cyc++;
            tick();
        end
        check_val("t3_ncyc", n_cyc, 32'd4);
        check_val("t3_rval", {31'h0, rsp_val}, 32'h1);
        check_val("t3_rerr", {31'h0, rsp_err}, 32'h1);
        check_val("t3_rdat", rsp_dat, 32'hFFFF_FFFF);
        consume();

        // 4. Ack on the timeout cycle wins
        issue(1'b0, 32'h0000_0080, 4'hF, 32'h0);
        tick();
        tick();
        tick();
        check_val("t4_cyc", {31'h0, wbm_cyc_o}, 32'h1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hCAFE_0004;
        tick();
        wbm_ack_i = 1'b0;
        check_val("t4_rval", {31'h0, rsp_val}, 32'h1);
        check_val("t4_rerr", {31'h0, rsp_err}, 32'h0);
        check_val("t4_rdat", rsp_dat, 32'hCAFE_0004);
        consume();

        // 5. Backpressured response, req_val held, spurious acks in RESP
        req_val = 1'b1;
        req_we  = 1'b0;
        req_adr = 32'h0000_0100;
        req_sel = 4'hF;
        req_dat = 32'h0;
        tick();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0BAD_F00D;
        tick();
        for (int i = 0; i < 10; i++) begin
            wbm_ack_i = i[0];
            wbm_dat_i = 32'h5555_0000 + i;
            check_val("t5_rdy",  {31'h0, req_rdy}, 32'h0);
            check_val("t5_cyc",  {31'h0, wbm_cyc_o}, 32'h0);
            check_val("t5_rval", {31'h0, rsp_val}, 32'h1);
            check_val("t5_rdat", rsp_dat, 32'h0BAD_F00D);
            tick();
        end
        wbm_ack_i = 1'b0;
        consume();
        check_val("t5_rval_clr", {31'h0, rsp_val}, 32'h0);
        check_val("t5_no_cyc",   {31'h0, wbm_cyc_o}, 32'h0);
        tick();
        req_val = 1'b0;
        check_val("t5_cyc2", {31'h0, wbm_cyc_o}, 32'h1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0000_0005;
        tick();
        wbm_ack_i = 1'b0;
        check_val("t5_rdat2", rsp_dat, 32'h0000_0005);
        consume();

        // 6. Reset mid-bus, then a spurious ack in IDLE
        issue(1'b1, 32'h0000_0200, 4'h1, 32'h7777_7777);
        check_val("t6_cyc_pre", {31'h0, wbm_cyc_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_cyc",  {31'h0, wbm_cyc_o}, 32'h0);
        check_val("t6_stb",  {31'h0, wbm_stb_o}, 32'h0);
        check_val("t6_adr",  wbm_adr_o, 32'h0);
        check_val("t6_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h9999_9999;
        tick();
        wbm_ack_i = 1'b0;
        tick();
        check_val("t6_rval", {31'h0, rsp_val}, 32'h0);
        check_val("t6_idle", {31'h0, busy}, 32'h0);
        check_val("t6_cyc2", {31'h0, wbm_cyc_o}, 32'h0);
        check_val("t6_rdat", rsp_dat, 32'h0);
        check_val("t6_rdy",  {31'h0, req_rdy}, 32'h1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
